// File: rtl/rob_fill_responder_pkg.sv
// Shared types and default widths for the ROB fill responder and its arbiter.
package rob_fill_pkg;

   localparam int NUM_REQ_DEF   = 4;
   localparam int ROB_IDX_W_DEF = 5;
   localparam int DATA_W_DEF    = 32;

   typedef struct packed {
      logic [ROB_IDX_W_DEF-1:0] idx;
      logic [DATA_W_DEF-1:0]    data;
      logic                     exc;
   } fill_req_t;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } stage_e;

endpackage

// File: rtl/rob_fill_responder_rr_arbiter.sv
// Round-robin arbiter: first valid at or after ptr_i (mod N) wins; grant gated by en_i.
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic [N-1:0]         valid_i,
   input  logic [$clog2(N)-1:0] ptr_i,
   input  logic                 en_i,
   output logic [N-1:0]         grant_o,
   output logic [$clog2(N)-1:0] win_o,
   output logic [$clog2(N)-1:0] next_ptr_o,
   output logic                 any_o
);

   localparam int PW = $clog2(N);

   always_comb begin
      logic [PW-1:0] cand;
      logic          found;
      grant_o = '0;
      win_o   = ptr_i;
      found   = 1'b0;
      cand    = '0;
      for (int i = 0; i < N; i++) begin
         cand = PW'((int'(ptr_i) + i) % N);
         if (!found && valid_i[cand]) begin
            found = 1'b1;
            win_o = cand;
         end
      end
      any_o = found;
      if (found && en_i) grant_o[win_o] = 1'b1;
      next_ptr_o = (int'(win_o) == N - 1) ? '0 : win_o + 1'b1;
   end

endmodule

// File: rtl/rob_fill_responder.sv
// ROB-side fill responder: round-robin grant of one fill per cycle into a single write register.
// Optional ROB_FILL_BYPASS_EN adds a same-cycle broadcast of the retiring write.
module rob_fill_responder
   import rob_fill_pkg::*;
#(
   parameter int NUM_REQ   = NUM_REQ_DEF,
   parameter int ROB_IDX_W = ROB_IDX_W_DEF,
   parameter int DATA_W    = DATA_W_DEF
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            fill_valid,
   input  logic [NUM_REQ*ROB_IDX_W-1:0]  fill_idx,
   input  logic [NUM_REQ*DATA_W-1:0]     fill_data,
   input  logic [NUM_REQ-1:0]            fill_exc,
   output logic [NUM_REQ-1:0]            fill_ack,
   input  logic                          flush,
   input  logic                          wr_ready,
   output logic                          wr_en,
   output logic [ROB_IDX_W-1:0]          wr_idx,
   output logic [DATA_W-1:0]             wr_data,
   output logic                          wr_exc,
`ifdef ROB_FILL_BYPASS_EN
   output logic                          bcast_valid,
   output logic [ROB_IDX_W-1:0]          bcast_idx,
   output logic [DATA_W-1:0]             bcast_data,
`endif
   output logic                          busy
);

   localparam int PW = $clog2(NUM_REQ);

   stage_e                 state_q, state_d;
   logic [PW-1:0]          rr_ptr_q, rr_ptr_d;
   logic [ROB_IDX_W-1:0]   idx_q, idx_d;
   logic [DATA_W-1:0]      data_q, data_d;
   logic                   exc_q, exc_d;

   logic                   can_accept;
   logic [NUM_REQ-1:0]     grant;
   logic [PW-1:0]          win, next_ptr;
   logic                   any_valid;
   logic                   ack_any;
   logic [ROB_IDX_W-1:0]   idx_arr  [NUM_REQ];
   logic [DATA_W-1:0]      data_arr [NUM_REQ];

   // A full stage can still accept when its write retires in the same cycle.
   assign can_accept = !flush && ((state_q == EMPTY) || wr_ready);

   rr_arbiter #(.N(NUM_REQ)) u_arb (
      .valid_i    (fill_valid),
      .ptr_i      (rr_ptr_q),
      .en_i       (can_accept),
      .grant_o    (grant),
      .win_o      (win),
      .next_ptr_o (next_ptr),
      .any_o      (any_valid)
   );

   assign ack_any  = can_accept && any_valid;
   assign fill_ack = grant;

   always_comb begin
      for (int r = 0; r < NUM_REQ; r++) begin
         idx_arr[r]  = fill_idx[r*ROB_IDX_W +: ROB_IDX_W];
         data_arr[r] = fill_data[r*DATA_W +: DATA_W];
      end
   end

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      idx_d    = idx_q;
      data_d   = data_q;
      exc_d    = exc_q;
      if (flush) begin
         state_d = EMPTY;
      end else if (ack_any) begin
         state_d  = FULL;
         rr_ptr_d = next_ptr;
         idx_d    = idx_arr[win];
         data_d   = data_arr[win];
         exc_d    = fill_exc[win];
      end else if ((state_q == FULL) && wr_ready) begin
         state_d = EMPTY;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= EMPTY;
         rr_ptr_q <= '0;
         idx_q    <= '0;
         data_q   <= '0;
         exc_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         idx_q    <= idx_d;
         data_q   <= data_d;
         exc_q    <= exc_d;
      end
   end

   assign wr_en   = (state_q == FULL);
   assign busy    = (state_q == FULL);
   assign wr_idx  = idx_q;
   assign wr_data = data_q;
   assign wr_exc  = exc_q;

`ifdef ROB_FILL_BYPASS_EN
   assign bcast_valid = wr_en && wr_ready && !flush;
   assign bcast_idx   = idx_q;
   assign bcast_data  = data_q;
`endif

endmodule

// File: tb/tb_rob_fill_responder.sv
// Directed self-checking bench for rob_fill_responder (default build; bypass checks with ROB_FILL_BYPASS_EN).
module tb_rob_fill_responder;
   import rob_fill_pkg::*;

   localparam int N  = 4;
   localparam int IW = 5;
   localparam int DW = 32;

   logic            clk;
   logic            rst_n;
   logic [N-1:0]    fill_valid;
   logic [N*IW-1:0] fill_idx;
   logic [N*DW-1:0] fill_data;
   logic [N-1:0]    fill_exc;
   logic [N-1:0]    fill_ack;
   logic            flush;
   logic            wr_ready;
   logic            wr_en;
   logic [IW-1:0]   wr_idx;
   logic [DW-1:0]   wr_data;
   logic            wr_exc;
   logic            busy;
`ifdef ROB_FILL_BYPASS_EN
   logic            bcast_valid;
   logic [IW-1:0]   bcast_idx;
   logic [DW-1:0]   bcast_data;
`endif

   int pass_cnt  = 0;
   int total_cnt = 0;

   rob_fill_responder #(.NUM_REQ(N), .ROB_IDX_W(IW), .DATA_W(DW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .fill_valid (fill_valid),
      .fill_idx   (fill_idx),
      .fill_data  (fill_data),
      .fill_exc   (fill_exc),
      .fill_ack   (fill_ack),
      .flush      (flush),
      .wr_ready   (wr_ready),
      .wr_en      (wr_en),
      .wr_idx     (wr_idx),
      .wr_data    (wr_data),
      .wr_exc     (wr_exc),
`ifdef ROB_FILL_BYPASS_EN
      .bcast_valid(bcast_valid),
      .bcast_idx  (bcast_idx),
      .bcast_data (bcast_data),
`endif
      .busy       (busy)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // driver tasks
   task automatic set_req(input int r, input fill_req_t req);
      fill_idx[r*IW +: IW]  = req.idx;
      fill_data[r*DW +: DW] = req.data;
      fill_exc[r]           = req.exc;
   endtask

   task automatic do_reset();
      rst_n      = 1'b0;
      fill_valid = '0;
      flush      = 1'b0;
      wr_ready   = 1'b1;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      fill_idx  = '0;
      fill_data = '0;
      fill_exc  = '0;
      do_reset();

      // reset state
      #1;
      check("rst_wr_en",   64'(wr_en),    64'h0);
      check("rst_busy",    64'(busy),     64'h0);
      check("rst_wr_idx",  64'(wr_idx),   64'h0);
      check("rst_wr_data", 64'(wr_data),  64'h0);
      check("rst_wr_exc",  64'(wr_exc),   64'h0);
      check("rst_ack",     64'(fill_ack), 64'h0);

      // single request from requester 2
      tick();
      set_req(2, '{idx: 5'd5, data: 32'hDEAD_BEEF, exc: 1'b0});
      fill_valid = 4'b0100;
      wr_ready   = 1'b1;
      #1;
      check("single_ack", 64'(fill_ack), 64'h4);
      tick();
      fill_valid = '0;
      #1;
      check("single_wr_en",   64'(wr_en),   64'h1);
      check("single_wr_idx",  64'(wr_idx),  64'h5);
      check("single_wr_data", 64'(wr_data), 64'hDEAD_BEEF);
      check("single_wr_exc",  64'(wr_exc),  64'h0);
      tick();
      check("single_idle", 64'(busy), 64'h0);

      // round-robin fairness from pointer 0
      do_reset();
      for (int r = 0; r < N; r++)
         set_req(r, '{idx: 5'(8 + r), data: 32'(32'h100 + r), exc: r[0]});
      fill_valid = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         #1;
         check($sformatf("rr_ack%0d", k), 64'(fill_ack), 64'(4'b0001 << (k % N)));
         if (k > 0) begin
            check($sformatf("rr_wr_en%0d", k), 64'(wr_en), 64'h1);
            check($sformatf("rr_wr_idx%0d", k), 64'(wr_idx), 64'(8 + (k - 1) % N));
         end
         tick();
      end
      fill_valid = '0;
      #1;
      check("rr_last_wr_en",   64'(wr_en),   64'h1);
      check("rr_last_wr_idx",  64'(wr_idx),  64'h8);
      check("rr_last_wr_data", 64'(wr_data), 64'h100);
      tick();
      check("rr_drain", 64'(busy), 64'h0);

      // back-pressure: idx 7 held, requester 1 waits
      do_reset();
      set_req(0, '{idx: 5'd7, data: 32'h77, exc: 1'b1});
      fill_valid = 4'b0001;
      tick();
      set_req(1, '{idx: 5'd9, data: 32'h55, exc: 1'b0});
      fill_valid = 4'b0010;
      wr_ready   = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         check($sformatf("bp_idx%0d", c), 64'(wr_idx),   64'h7);
         check($sformatf("bp_en%0d", c),  64'(wr_en),    64'h1);
         check($sformatf("bp_ack%0d", c), 64'(fill_ack), 64'h0);
         tick();
      end
      wr_ready = 1'b1;
      #1;
      check("bp_release_ack", 64'(fill_ack), 64'h2);
      check("bp_release_idx", 64'(wr_idx),   64'h7);
      check("bp_release_exc", 64'(wr_exc),   64'h1);
      tick();
      fill_valid = '0;
      #1;
      check("bp_next_idx",  64'(wr_idx),  64'h9);
      check("bp_next_data", 64'(wr_data), 64'h55);

      // flush while FULL with requester 0 valid (rr pointer now 2)
      set_req(0, '{idx: 5'd4, data: 32'hF00D, exc: 1'b0});
      fill_valid = 4'b0001;
      flush      = 1'b1;
      #1;
      check("flush_ack", 64'(fill_ack), 64'h0);
`ifdef ROB_FILL_BYPASS_EN
      check("flush_bcast", 64'(bcast_valid), 64'h0);
`endif
      tick();
      flush = 1'b0;
      #1;
      check("flush_wr_en", 64'(wr_en),    64'h0);
      check("flush_busy",  64'(busy),     64'h0);
      check("flush_reack", 64'(fill_ack), 64'h1);
      tick();
      fill_valid = '0;
      #1;
      check("flush_wr_idx", 64'(wr_idx), 64'h4);

      // async reset mid-cycle while FULL
      tick();
      set_req(3, '{idx: 5'd1, data: 32'hABC, exc: 1'b0});
      fill_valid = 4'b1000;
      wr_ready   = 1'b0;
      tick();
      fill_valid = '0;
      #1;
      check("ar_full", 64'(busy), 64'h1);
      #1;
      rst_n = 1'b0;
      #1;
      check("ar_wr_en",  64'(wr_en),  64'h0);
      check("ar_busy",   64'(busy),   64'h0);
      check("ar_wr_idx", 64'(wr_idx), 64'h0);
      tick();
      rst_n      = 1'b1;
      wr_ready   = 1'b1;
      fill_valid = 4'b1111;
      #1;
      check("ar_first_grant", 64'(fill_ack), 64'h1);
      tick();
      fill_valid = '0;

`ifdef ROB_FILL_BYPASS_EN
      // bypass broadcast of a retiring write
      do_reset();
      set_req(2, '{idx: 5'd3, data: 32'h12, exc: 1'b0});
      fill_valid = 4'b0100;
      tick();
      fill_valid = '0;
      #1;
      check("bc_valid", 64'(bcast_valid), 64'h1);
      check("bc_idx",   64'(bcast_idx),   64'h3);
      check("bc_data",  64'(bcast_data),  64'h12);
      flush = 1'b1;
      #1;
      check("bc_flush", 64'(bcast_valid), 64'h0);
      tick();
      flush = 1'b0;
`endif

      // report
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/rob_fill_responder.md
# rob_fill_responder

ROB-side responder of the fill protocol used by reservation stations. Accepts completed-result fill requests from up to NUM_REQ reservation-station/execution pairs, grants one per cycle by round-robin, registers it, and issues a single write to the ROB result array. Flush and back-pressure come from ROB control.

## Interface
- NUM_REQ, 4: number of fill requesters; must be at least 2.
- ROB_IDX_W, 5: ROB entry index width.
- DATA_W, 32: result data width.

- clk  in  1  block clock.
- rst_n  in  1  asynchronous, active-low reset.
- fill_valid  in  NUM_REQ  per-requester fill request.
- fill_idx  in  NUM_REQ*ROB_IDX_W  target ROB entry; requester r uses slice r.
- fill_data  in  NUM_REQ*DATA_W  result value.
- fill_exc  in  NUM_REQ  result raised an exception.
- fill_ack  out  NUM_REQ  one-hot grant; request accepted at this edge.
- flush  in  1  pipeline flush from ROB control.
- wr_ready  in  1  ROB array can take a write this cycle.
- wr_en  out  1  write valid.
- wr_idx  out  ROB_IDX_W  write entry.
- wr_data  out  DATA_W  write data.
- wr_exc  out  1  write exception flag.
- busy  out  1  output stage holds a pending write.

## Operation
- Output stage: one register, states EMPTY and FULL.
- can_accept = EMPTY, or (FULL and wr_ready). flush forces can_accept = 0.
- Arbitration is combinational. Search starts at rr_ptr, increasing index mod NUM_REQ. The first asserted fill_valid wins. fill_ack[win] = can_accept and any valid.
- On ack:
  - capture idx/data/exc of the winner; the stage becomes or stays FULL;
  - rr_ptr <= (win+1) mod NUM_REQ.
- With no ack, rr_ptr holds.
- FULL and wr_ready with no new ack: go to EMPTY.
- FULL and not wr_ready: hold all fields stable. No ack is issued.
- flush: the stage goes EMPTY at the next edge. No ack is issued in the flush cycle, and a pending write is dropped. rr_ptr is kept.
- Requesters hold valid/payload until acked. The responder does not check for duplicate indices.

## Timing
- Reset values: wr_en=0, wr_idx=0, wr_data=0, wr_exc=0, busy=0, rr_ptr=0, stage EMPTY. fill_ack=0 while the stage is empty and no request is valid.
- Latency: ack in cycle N, then wr_en=1 in cycle N+1 with the captured payload.
- Throughput: one fill per cycle while wr_ready stays 1.
- wr_en = busy = FULL.
- The write retires on a cycle with wr_en and wr_ready both high.
- rst_n low mid-operation: all state returns to reset values immediately, without waiting for clk.

## Configuration
- ROB_FILL_BYPASS_EN defined:
  - adds outputs bcast_valid (1), bcast_idx (ROB_IDX_W) and bcast_data (DATA_W);
  - they mirror the retiring write (wr_en and wr_ready and not flush) in the same cycle, so reservation stations can wake dependents.
- Undefined: these ports do not exist, and dependents wake from ROB reads only.

## Structure
- Shared package rob_fill_pkg holds:
  - typedef fill_req_t {idx, data, exc};
  - default width constants;
  - the output-stage state enum {EMPTY, FULL}.
- Sub-module rr_arbiter (parameter N) produces the one-hot grant and the next pointer from the valid vector and rr_ptr. The output register stays in rob_fill_responder.

## Test plan
- Single request: requester 2 sends idx=5, data=0xDEAD_BEEF, exc=0, wr_ready=1.
  - Expect: fill_ack=0100 in cycle N; wr_en=1, wr_idx=5, wr_data=0xDEADBEEF in N+1; busy=0 in N+2.
- Round-robin fairness: all 4 requesters valid continuously, wr_ready=1.
  - Expect grants 0,1,2,3,0, one per cycle, and 5 consecutive writes.
- Back-pressure: wr_ready=0 for 3 cycles while FULL with idx=7 and requester 1 pending.
  - Expect: wr_idx held at 7, fill_ack=0 throughout.
  - After wr_ready=1: write retires and requester 1 is acked in the same cycle.
- Flush: flush=1 while FULL and requester 0 valid.
  - Expect: no ack; stage EMPTY next cycle; wr_en=0.
  - Requester 0 is acked the cycle after flush drops.
- Async reset: rst_n=0 mid-cycle while FULL.
  - Expect: wr_en and busy=0 before the next edge; first grant after reset goes to requester 0.
- With ROB_FILL_BYPASS_EN defined: a retiring write of idx=3, data=0x12 gives bcast_valid=1, bcast_idx=3, bcast_data=0x12 in the same cycle. bcast_valid=0 when flush=1.
